// File: rtl/gpr_write_arbiter.sv
// rtl/gpr_write_arbiter.sv - round-robin write arbiter in front of a GPR bank
module gpr_write_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 16,
    parameter int NUM_REG = 8,
    parameter int ADDR_W  = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      hold,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        ack,
    output logic [NUM_REG-1:0]        gpr_write,
    output logic [DATA_W-1:0]         gpr_data,
    output logic                      addr_err
);

    localparam int PTR_W = $clog2(NUM_REQ);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t              state_q, state_d;
    logic [PTR_W-1:0]    ptr_q, ptr_d;
    logic [NUM_REQ-1:0]  ack_q, ack_d;
    logic [NUM_REG-1:0]  gpr_write_q, gpr_write_d;
    logic [DATA_W-1:0]   gpr_data_q, gpr_data_d;
    logic                addr_err_q, addr_err_d;

    logic [NUM_REQ-1:0]  eligible;
    logic                found;
    logic [PTR_W-1:0]    win;
    logic [ADDR_W-1:0]   win_addr;
    logic [DATA_W-1:0]   win_data;

    // Round-robin scan starting just after the last winner; a requester
    // being acked this cycle is masked so its held request is not taken twice.
    always_comb begin
        eligible = req & ~((state_q == GRANT) ? ack_q : '0);
        found    = 1'b0;
        win      = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (!found && eligible[(int'(ptr_q) + k) % NUM_REQ]) begin
                found = 1'b1;
                win   = PTR_W'((int'(ptr_q) + k) % NUM_REQ);
            end
        end
        win_addr = req_addr[int'(win)*ADDR_W +: ADDR_W];
        win_data = req_data[int'(win)*DATA_W +: DATA_W];
    end

    // Next-state and registered-output computation; hold blocks any new grant.
    always_comb begin
        state_d     = IDLE;
        ptr_d       = ptr_q;
        ack_d       = '0;
        gpr_write_d = '0;
        gpr_data_d  = gpr_data_q;
        addr_err_d  = 1'b0;
        if (found && !hold) begin
            state_d    = GRANT;
            ptr_d      = win;
            ack_d[win] = 1'b1;
            gpr_data_d = win_data;
            if (32'(win_addr) >= NUM_REG) begin
                addr_err_d = 1'b1;
            end else begin
                for (int r = 0; r < NUM_REG; r++) begin
                    gpr_write_d[r] = (win_addr == ADDR_W'(r));
                end
            end
        end
    end

    // State and output registers; reset drops any grant that was about to issue.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            ptr_q       <= PTR_W'(NUM_REQ - 1);
            ack_q       <= '0;
            gpr_write_q <= '0;
            gpr_data_q  <= '0;
            addr_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            ack_q       <= ack_d;
            gpr_write_q <= gpr_write_d;
            gpr_data_q  <= gpr_data_d;
            addr_err_q  <= addr_err_d;
        end
    end

    assign ack       = ack_q;
    assign gpr_write = gpr_write_q;
    assign gpr_data  = gpr_data_q;
    assign addr_err  = addr_err_q;

endmodule
